mp_pf_icache_prefetch_seq: RTL

Prefetch sequencer for the multi-port private-fetch instruction cache. It accepts one prefetch command per handshake (`pf_addr`/`pf_size`/`pf_req` from the icache control unit). It expands the command into line-granular refill requests toward the cache refill port, tracks outstanding refills, and reports completion back to the control unit with `pf_ack`/`pf_done`. It sits on the cache side of the control-unit bus, between the control-unit register file and the icache refill arbiter.

---
 rtl/mp_pf_icache_prefetch_seq.sv | 113 +++++++++++
 1 files changed

// File: rtl/mp_pf_icache_prefetch_seq.sv
// Prefetch sequencer: expands a line-count prefetch command into line-aligned
// refill requests, bounds outstanding refills and reports ack/done.
module mp_pf_icache_prefetch_seq #(
  parameter int unsigned LINE_BYTES = 16,
  parameter int unsigned MAX_OUT    = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        pf_req_i,
  input  logic [31:0] pf_addr_i,
  input  logic [7:0]  pf_size_i,
  output logic        pf_ack_o,
  output logic        pf_done_o,
  input  logic        flush_i,
  output logic        fetch_req_o,
  output logic [31:0] fetch_addr_o,
  input  logic        fetch_gnt_i,
  input  logic        fetch_rvalid_i,
  output logic        busy_o
);

  localparam int unsigned OW = $clog2(MAX_OUT + 1);
  localparam logic [OW-1:0] MAX_OUT_C = OW'(MAX_OUT);
  localparam logic [OW-1:0] ONE_C     = OW'(1);
  localparam logic [31:0]   LINE_INC  = 32'(LINE_BYTES);
  localparam logic [31:0]   LINE_MASK = ~(LINE_INC - 32'd1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [31:0]    cur_addr_q;
  logic [7:0]     lines_left_q;
  logic [OW-1:0]  outstanding_q;
  logic           abort_q;
  logic           pending_q;
  logic           ack_q;
  logic           fetch_req;
  logic           grant;
  logic           rvalid_eff;

  // A request raised but not granted stays up regardless of abort or the
  // outstanding limit, so the master never sees a dropped request.
  always_comb begin
    state_d    = state_q;
    fetch_req  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pf_req_i) state_d = (pf_size_i == 8'd0) ? DONE : ISSUE;
      end
      ISSUE: begin
        fetch_req = pending_q || (!abort_q && (outstanding_q < MAX_OUT_C));
        if (fetch_req && fetch_gnt_i && (lines_left_q == 8'd1)) begin
          state_d = DRAIN;
        end else if (abort_q && (!fetch_req || fetch_gnt_i)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if ((outstanding_q == '0) ||
            ((outstanding_q == ONE_C) && fetch_rvalid_i)) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    grant      = fetch_req && fetch_gnt_i;
    rvalid_eff = fetch_rvalid_i && (outstanding_q != '0);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      cur_addr_q    <= '0;
      lines_left_q  <= '0;
      outstanding_q <= '0;
      abort_q       <= 1'b0;
      pending_q     <= 1'b0;
      ack_q         <= 1'b0;
    end else begin
      state_q   <= state_d;
      ack_q     <= (state_q == IDLE) && pf_req_i;
      pending_q <= fetch_req && !fetch_gnt_i;

      if ((state_q == IDLE) && pf_req_i) begin
        cur_addr_q   <= pf_addr_i & LINE_MASK;
        lines_left_q <= pf_size_i;
        abort_q      <= 1'b0;
      end else if (grant) begin
        cur_addr_q   <= cur_addr_q + LINE_INC;
        lines_left_q <= lines_left_q - 8'd1;
      end

      if ((state_q == ISSUE) && flush_i) abort_q <= 1'b1;

      // Grant and return in the same cycle cancel; a stray return at zero is dropped.
      if (grant && !rvalid_eff)      outstanding_q <= outstanding_q + ONE_C;
      else if (!grant && rvalid_eff) outstanding_q <= outstanding_q - ONE_C;
    end
  end

  assign fetch_req_o  = fetch_req;
  assign fetch_addr_o = fetch_req ? cur_addr_q : '0;
  assign pf_ack_o     = ack_q;
  assign pf_done_o    = (state_q == DONE);
  assign busy_o       = (state_q != IDLE);

endmodule
